// File: rtl/xalu_muldiv.sv
// HI/LO multiply/divide unit for the E-stage XALU issue path.
// Fixed-latency: answer is computed at issue, held pending, committed after N cycles.
module xalu_muldiv #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic        src,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] result,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

    localparam logic [31:0] MUL_LOAD = 32'(MUL_CYCLES - 1);
    localparam logic [31:0] DIV_LOAD = 32'(DIV_CYCLES - 1);

    logic [0:0]  state;
    logic [31:0] cnt;
    logic [63:0] pend;
    logic        pend_ok;

    logic        is_md;
    logic        b_nz;
    logic [63:0] smul;
    logic [63:0] umul;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] mq;
    logic [31:0] mr;
    logic [31:0] squo;
    logic [31:0] srem;
    logic [31:0] uquo;
    logic [31:0] urem;
    logic [63:0] ans;
    logic        ans_ok;
    logic [31:0] load;

    assign is_md = start & ~op[2];
    assign b_nz  = |b;

    assign smul = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign umul = {32'd0, a} * {32'd0, b};

    // Signed divide on magnitudes; 0x80000000 / -1 wraps back to 0x80000000.
    assign a_mag = a[31] ? (~a + 32'd1) : a;
    assign b_mag = b[31] ? (~b + 32'd1) : b;
    assign mq    = b_nz ? (a_mag / b_mag) : 32'd0;
    assign mr    = b_nz ? (a_mag % b_mag) : 32'd0;
    assign squo  = (a[31] ^ b[31]) ? (~mq + 32'd1) : mq;
    assign srem  = a[31] ? (~mr + 32'd1) : mr;
    assign uquo  = b_nz ? (a / b) : 32'd0;
    assign urem  = b_nz ? (a % b) : 32'd0;

    always_comb begin
        ans    = '0;
        ans_ok = 1'b1;
        load   = MUL_LOAD;
        case (op[1:0])
            2'b00: ans = smul;
            2'b01: ans = umul;
            2'b10: begin
                ans    = {srem, squo};
                ans_ok = b_nz;
                load   = DIV_LOAD;
            end
            default: begin
                ans    = {urem, uquo};
                ans_ok = b_nz;
                load   = DIV_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            pend    <= '0;
            pend_ok <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (is_md) begin
                        pend    <= ans;
                        pend_ok <= ans_ok;
                        cnt     <= load;
                        state   <= S_RUN;
                    end else if (start && op == OP_MTHI) begin
                        hi <= a;
                    end else if (start && op == OP_MTLO) begin
                        lo <= a;
                    end
                end
                default: begin
                    if (cnt == '0) begin
                        if (pend_ok) begin
                            hi <= pend[63:32];
                            lo <= pend[31:0];
                        end
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt - 32'd1;
                    end
                end
            endcase
        end
    end

    assign busy   = (state == S_RUN);
    assign result = src ? hi : lo;

endmodule

// File: tb/tb_xalu_muldiv.sv
// Self-checking bench for xalu_muldiv: cycle model with 64-bit arithmetic
// plus directed vectors with hand-computed HI/LO values.
module tb_xalu_muldiv;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic        src;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] result;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp = 0;
    int n_bad = 0;

    xalu_muldiv #(.MUL_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .op(op),
        .src(src),
        .a(a),
        .b(b),
        .busy(busy),
        .result(result),
        .hi(hi),
        .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: remaining busy cycles plus the answer to commit.
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    int          m_left = 0;
    logic [63:0] m_pend = '0;
    logic        m_commit = 1'b0;

    always @(posedge clk or posedge reset) begin
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub, uq, ur;
        logic [63:0]     t;
        if (reset) begin
            m_hi = '0;
            m_lo = '0;
            m_left = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && m_commit) begin
                t = m_pend;
                m_hi = t[63:32];
                m_lo = t[31:0];
            end
        end else if (start) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            ua = longint'(a);
            ub = longint'(b);
            case (op)
                3'd0: begin
                    m_pend = sa * sb;
                    m_commit = 1'b1;
                    m_left = MC;
                end
                3'd1: begin
                    m_pend = ua * ub;
                    m_commit = 1'b1;
                    m_left = MC;
                end
                3'd2: begin
                    m_commit = (b != 0);
                    if (b != 0) begin
                        sq = sa / sb;
                        sr = sa % sb;
                        t = sq;
                        m_pend[31:0] = t[31:0];
                        t = sr;
                        m_pend[63:32] = t[31:0];
                    end
                    m_left = DC;
                end
                3'd3: begin
                    m_commit = (b != 0);
                    if (b != 0) begin
                        uq = ua / ub;
                        ur = ua % ub;
                        m_pend = {ur[31:0], uq[31:0]};
                    end
                    m_left = DC;
                end
                3'd4: m_hi = a;
                3'd5: m_lo = a;
                default: ;
            endcase
        end
    end

    always @(posedge clk) begin
        #1;
        check("busy", {31'd0, busy}, {31'd0, m_left > 0});
        check("hi", hi, m_hi);
        check("lo", lo, m_lo);
        check("result", result, src ? m_hi : m_lo);
    end

    task automatic tick();
        @(negedge clk);
        src = 1'($urandom_range(0, 1));
    endtask

    task automatic issue(logic [2:0] o, logic [31:0] x, logic [31:0] y);
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(string name, int exp, int already);
        int n = already;
        while (busy && n < 200) begin
            n++;
            tick();
        end
        check(name, 32'(n), 32'(exp));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op = '0;
        src = 1'b0;
        a = '0;
        b = '0;
        repeat (3) tick();
        reset = 1'b0;
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        tick();

        issue(3'd0, 32'hFFFF_FFF9, 32'd3);
        wait_done("mult_cycles", MC, 0);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFEB);

        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        tick();
        check("multu_old_hi", hi, 32'hFFFF_FFFF);
        check("multu_old_lo", lo, 32'hFFFF_FFEB);
        wait_done("multu_cycles", MC, 1);
        check("multu_hi", hi, 32'hFFFF_FFFE);
        check("multu_lo", lo, 32'h0000_0001);

        issue(3'd2, 32'hFFFF_FFF9, 32'd2);
        wait_done("div_cycles", DC, 0);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);

        issue(3'd3, 32'd7, 32'd2);
        wait_done("divu_cycles", DC, 0);
        check("divu_lo", lo, 32'd3);
        check("divu_hi", hi, 32'd1);

        issue(3'd4, 32'h11, 32'd0);
        check("mthi_busy", {31'd0, busy}, 32'd0);
        issue(3'd5, 32'h22, 32'd0);
        issue(3'd2, 32'd5, 32'd0);
        wait_done("div0_cycles", DC, 0);
        check("div0_hi", hi, 32'h11);
        check("div0_lo", lo, 32'h22);

        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("divovf_cycles", DC, 0);
        check("divovf_lo", lo, 32'h8000_0000);
        check("divovf_hi", hi, 32'h0);

        issue(3'd4, 32'h1234, 32'd0);
        src = 1'b1;
        #1;
        check("mthi_hi", hi, 32'h1234);
        check("mthi_result", result, 32'h1234);
        check("mthi_busy2", {31'd0, busy}, 32'd0);

        issue(3'd0, 32'd3, 32'd4);
        issue(3'd5, 32'h55, 32'd0);
        check("mtlo_run_lo", lo, 32'h8000_0000);
        wait_done("mult34_cycles", MC, 1);
        check("mult34_lo", lo, 32'd12);
        check("mult34_hi", hi, 32'd0);

        issue(3'd6, 32'hDEAD, 32'hBEEF);
        issue(3'd7, 32'hDEAD, 32'hBEEF);
        check("rsvd_busy", {31'd0, busy}, 32'd0);
        check("rsvd_lo", lo, 32'd12);

        issue(3'd0, 32'd5, 32'd5);
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        tick();
        reset = 1'b0;
        tick();

        issue(3'd0, 32'd2, 32'd3);
        wait_done("mult23_cycles", MC, 0);
        check("mult23_lo", lo, 32'd6);
        check("mult23_hi", hi, 32'd0);

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
